// File: rtl/vga_timing_gen.sv
// VGA timing and test-pattern generator: free-running h/v counters, registered sync/de/coords
// and one of four test patterns, with the pattern select latched at each frame origin.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BP     = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CW       = 4,
  parameter int CNTW     = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pix_en,
  input  logic [1:0]      mode,
  input  logic [3*CW-1:0] solid_rgb,
  output logic            hsync,
  output logic            vsync,
  output logic            de,
  output logic [CNTW-1:0] x,
  output logic [CNTW-1:0] y,
  output logic [CW-1:0]   red,
  output logic [CW-1:0]   green,
  output logic [CW-1:0]   blue,
  output logic            frame_start,
  output logic [7:0]      frame_cnt
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int BAR_W    = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  if (H_TOTAL > (2 ** CNTW) || V_TOTAL > (2 ** CNTW)) begin : g_cnt_range
    $error("vga_timing_gen: CNTW too narrow for H_TOTAL/V_TOTAL");
  end

  // Pattern colour for an active pixel, packed {r,g,b}; bar index saturates so the
  // last bar absorbs the remainder of H_ACTIVE/8.
  function automatic logic [3*CW-1:0] pattern(input logic [1:0]      m,
                                              input logic [CNTW-1:0] px,
                                              input logic [CNTW-1:0] py,
                                              input logic [3*CW-1:0] solid);
    logic [3*CW-1:0] rgb;
    logic [2:0]      bar;
    int              idx;
    idx = int'(px) / BAR_W;
    if (idx > 7) idx = 7;
    case (idx)
      0:       bar = 3'b111;
      1:       bar = 3'b110;
      2:       bar = 3'b011;
      3:       bar = 3'b010;
      4:       bar = 3'b101;
      5:       bar = 3'b100;
      6:       bar = 3'b001;
      default: bar = 3'b000;
    endcase
    case (m)
      2'd0:    rgb = {{CW{bar[2]}}, {CW{bar[1]}}, {CW{bar[0]}}};
      2'd1:    rgb = (px[5] ^ py[5]) ? '0 : '1;
      2'd2:    rgb = solid;
      default: rgb = {3{px[CW+3:4]}};
    endcase
    return rgb;
  endfunction

  logic [CNTW-1:0] hc, vc;
  logic [1:0]      mode_q;
  logic            h_last, v_last, at_origin, act, hs_on, vs_on;
  logic [1:0]      mode_cur;
  logic [3*CW-1:0] rgb_nxt;

  always_comb begin
    h_last    = (int'(hc) == H_TOTAL - 1);
    v_last    = (int'(vc) == V_TOTAL - 1);
    at_origin = (hc == '0) && (vc == '0);
    act       = (int'(hc) < H_ACTIVE) && (int'(vc) < V_ACTIVE);
    hs_on     = (int'(hc) >= HS_START) && (int'(hc) < HS_END);
    vs_on     = (int'(vc) >= VS_START) && (int'(vc) < VS_END);
    // The origin pixel already uses the mode being latched on this cycle.
    mode_cur  = at_origin ? mode : mode_q;
    rgb_nxt   = act ? pattern(mode_cur, hc, vc, solid_rgb) : '0;
  end

  // Counter stage -> registered output stage (outputs describe hc/vc of the previous enabled cycle)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc          <= '0;
      vc          <= '0;
      mode_q      <= '0;
      frame_cnt   <= '0;
      frame_start <= 1'b0;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
    end else if (pix_en) begin
      hc <= h_last ? '0 : hc + 1'b1;
      if (h_last) vc <= v_last ? '0 : vc + 1'b1;
      if (at_origin) begin
        mode_q    <= mode;
        frame_cnt <= frame_cnt + 8'd1;
      end
      frame_start          <= at_origin;
      de                   <= act;
      x                    <= act ? hc : '0;
      y                    <= act ? vc : '0;
      hsync                <= hs_on ? HS_POL : ~HS_POL;
      vsync                <= vs_on ? VS_POL : ~VS_POL;
      {red, green, blue}   <= rgb_nxt;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen on a small mode, against a position-based reference model.
module tb_vga_timing_gen;
  localparam int HA = 84, HFP = 4, HSW = 8, HBP = 4;
  localparam int VA = 40, VFP = 2, VSW = 3, VBP = 3;
  localparam int CW = 4, CNTW = 11;
  localparam bit HSP = 1'b1, VSP = 1'b0;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FT = HT * VT;
  localparam int NCYC = 30000;
  localparam int RST_CYC = 15000;

  logic            clk = 1'b0;
  logic            rst, pix_en;
  logic [1:0]      mode;
  logic [3*CW-1:0] solid_rgb;
  logic            hsync, vsync, de, frame_start;
  logic [CNTW-1:0] x, y;
  logic [CW-1:0]   red, green, blue;
  logic [7:0]      frame_cnt;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HSP), .VS_POL(VSP), .CW(CW), .CNTW(CNTW)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .mode(mode), .solid_rgb(solid_rgb),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .red(red), .green(green), .blue(blue),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int k;
  int frame_mode;
  logic        e_hs, e_vs, e_de, e_fs;
  int          e_x, e_y, e_rgb, e_fc;
  logic [2:0]  bar_tab [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (enabled edge %0d)", tag, obs, exp, k);
    end
  endtask

  function automatic int chan(input logic on);
    return on ? (1 << CW) - 1 : 0;
  endfunction

  function automatic int pack_rgb(input int r, input int g, input int b);
    return (r << (2 * CW)) | (g << CW) | b;
  endfunction

  task automatic model_reset();
    k = 0;
    e_hs = ~HSP; e_vs = ~VSP; e_de = 1'b0; e_fs = 1'b0;
    e_x = 0; e_y = 0; e_rgb = 0; e_fc = 0;
  endtask

  // One enabled edge: the position is simply the count of enabled edges since reset.
  task automatic model_step();
    int p, hc, vc, bi, lvl;
    logic [2:0] c;
    p  = k % FT;
    hc = p % HT;
    vc = p / HT;
    if (p == 0) frame_mode = int'(mode);
    e_de = (hc < HA) && (vc < VA);
    e_x  = e_de ? hc : 0;
    e_y  = e_de ? vc : 0;
    e_hs = (hc >= HA + HFP && hc < HA + HFP + HSW) ? HSP : ~HSP;
    e_vs = (vc >= VA + VFP && vc < VA + VFP + VSW) ? VSP : ~VSP;
    e_fs = (p == 0);
    e_fc = (k / FT + 1) % 256;
    e_rgb = 0;
    if (e_de) begin
      case (frame_mode)
        0: begin
          bi = hc / (HA / 8);
          if (bi > 7) bi = 7;
          c = bar_tab[bi];
          e_rgb = pack_rgb(chan(c[2]), chan(c[1]), chan(c[0]));
        end
        1: e_rgb = (((hc / 32) + (vc / 32)) % 2 == 0) ? pack_rgb(chan(1'b1), chan(1'b1), chan(1'b1)) : 0;
        2: e_rgb = int'(solid_rgb);
        default: begin
          lvl = (hc / 16) % (1 << CW);
          e_rgb = pack_rgb(lvl, lvl, lvl);
        end
      endcase
    end
    k++;
  endtask

  task automatic check_all();
    check("hsync", 32'(hsync), 32'(e_hs));
    check("vsync", 32'(vsync), 32'(e_vs));
    check("de", 32'(de), 32'(e_de));
    check("x", 32'(x), e_x);
    check("y", 32'(y), e_y);
    check("rgb", 32'({red, green, blue}), e_rgb);
    check("frame_start", 32'(frame_start), 32'(e_fs));
    check("frame_cnt", 32'(frame_cnt), e_fc);
  endtask

  initial begin
    rst = 1'b1; pix_en = 1'b0; mode = 2'd0; solid_rgb = 12'hA5C;
    frame_mode = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_all();
    @(negedge clk) rst = 1'b0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (cyc >= 8000 && cyc < 12000) pix_en = (cyc % 2 == 0);
      else pix_en = ($urandom_range(0, 3) != 0);
      if (k % FT == FT / 2) mode = 2'((k / FT + 1) % 4);
      if ($urandom_range(0, 2999) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) solid_rgb = 12'($urandom);
      @(posedge clk);
      #1;
      if (pix_en) model_step();
      check_all();
      if (cyc == RST_CYC) begin
        #2 rst = 1'b1;
        pix_en = 1'b0;
        #1 model_reset();
        check_all();
        repeat (2) @(posedge clk);
        #1 check_all();
        @(negedge clk) rst = 1'b0;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
